// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen
// Function : Fetch-group PC generator with redirect handling and an optional
//            return-address stack (compiled in when FETCH_PC_RAS_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_gen #(
    parameter int              XLEN        = 32,
    parameter int              FETCH_WIDTH = 2,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0001_0000,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 hold,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]     accept_cnt,
    input  logic                                 redir_valid,
    input  logic [1:0]                           redir_type,
    input  logic [XLEN-1:0]                      redir_pc,
    input  logic [XLEN-1:0]                      redir_off,
    input  logic [XLEN-1:0]                      redir_base,
    input  logic                                 ras_push,
    input  logic [XLEN-1:0]                      ras_push_addr,
    input  logic                                 ras_pop,
    output logic [XLEN*FETCH_WIDTH-1:0]          pc_vec,
    output logic [FETCH_WIDTH-1:0]               slot_valid,
    output logic                                 misalign,
    output logic                                 ras_empty
);

    localparam int                 c_ACC_W = $clog2(FETCH_WIDTH+1);
    localparam logic [c_ACC_W-1:0] c_FW    = c_ACC_W'(FETCH_WIDTH);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic              r_misalign;
    logic              w_mis_nxt;
    logic [XLEN-1:0]   w_target;
    logic [c_ACC_W-1:0] w_acc;
    logic [XLEN-1:0]   w_adv;
    logic              w_pop_hit;
    logic [XLEN-1:0]   w_ras_top;

    // Reserved type 11 falls through to the jalr form.
    assign w_target = (redir_type[1] == 1'b0) ? (redir_pc + redir_off)
                                              : {redir_base[XLEN-1:1], 1'b0};
    assign w_acc    = (accept_cnt > c_FW) ? c_FW : accept_cnt;
    assign w_adv    = XLEN'({w_acc, 2'b00});

`ifdef FETCH_PC_RAS_EN
    localparam int                 c_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int                 c_CNT_W = $clog2(RAS_DEPTH+1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]    r_ras_mem [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_ras_top;
    logic [c_CNT_W-1:0] r_ras_cnt;
    logic [c_PTR_W-1:0] w_wr_idx;
    logic               w_push_fire;

    assign w_push_fire = ras_push && !redir_valid;
    assign w_pop_hit   = ras_pop && (r_ras_cnt != '0) && !redir_valid && (r_state != ST_BOOT);
    assign w_ras_top   = r_ras_mem[r_ras_top];
    // A simultaneous pop frees the top slot, so the push lands there instead.
    assign w_wr_idx    = w_pop_hit ? r_ras_top : (r_ras_top + 1'b1);
    assign ras_empty   = (r_ras_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ras_top <= '0;
            r_ras_cnt <= '0;
        end else begin
            case ({w_push_fire, w_pop_hit})
                2'b10: begin
                    r_ras_top <= r_ras_top + 1'b1;
                    if (r_ras_cnt != c_DEPTH) begin
                        r_ras_cnt <= r_ras_cnt + 1'b1;
                    end
                end
                2'b01: begin
                    r_ras_top <= r_ras_top - 1'b1;
                    r_ras_cnt <= r_ras_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_fire) begin
            r_ras_mem[w_wr_idx] <= ras_push_addr;
        end
    end
`else
    logic w_unused_ras;

    assign w_unused_ras = ^{ras_push, ras_pop, ras_push_addr};
    assign w_pop_hit    = 1'b0;
    assign w_ras_top    = '0;
    assign ras_empty    = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_fetch_pc;
        w_mis_nxt   = r_misalign;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN, ST_BUBBLE: begin
                if (redir_valid) begin
                    w_pc_nxt    = {w_target[XLEN-1:2], 2'b00};
                    w_mis_nxt   = w_target[1];
                    w_state_nxt = ST_BUBBLE;
                end else if (w_pop_hit) begin
                    w_pc_nxt    = w_ras_top;
                    w_state_nxt = ST_BUBBLE;
                end else if (en) begin
                    if (r_state == ST_BUBBLE) begin
                        w_state_nxt = ST_RUN;
                    end else if (!hold) begin
                        w_pc_nxt = r_fetch_pc + w_adv;
                    end
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_fetch_pc <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_pc_nxt;
            r_misalign <= w_mis_nxt;
        end
    end

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
        assign pc_vec[i*XLEN +: XLEN] = r_fetch_pc + XLEN'(4*i);
    end

    assign slot_valid = {FETCH_WIDTH{r_state == ST_RUN}};
    assign misalign   = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_gen
// Function : Scoreboard bench for fetch_pc_gen (directed + random stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_gen;

    localparam int          XLEN      = 32;
    localparam int          FW        = 2;
    localparam logic [31:0] RESET_PC  = 32'h0001_0000;
    localparam int          RAS_DEPTH = 4;
`ifdef FETCH_PC_RAS_EN
    localparam bit          RAS_ON    = 1'b1;
`else
    localparam bit          RAS_ON    = 1'b0;
`endif
    localparam int S_BOOT = 0, S_RUN = 1, S_BUBBLE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en, hold, redir_valid, ras_push, ras_pop;
    logic [1:0]  accept_cnt, redir_type;
    logic [31:0] redir_pc, redir_off, redir_base, ras_push_addr;
    logic [63:0] pc_vec;
    logic [1:0]  slot_valid;
    logic        misalign, ras_empty;

    fetch_pc_gen #(
        .XLEN(XLEN), .FETCH_WIDTH(FW), .RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .accept_cnt(accept_cnt),
        .redir_valid(redir_valid), .redir_type(redir_type), .redir_pc(redir_pc),
        .redir_off(redir_off), .redir_base(redir_base), .ras_push(ras_push),
        .ras_push_addr(ras_push_addr), .ras_pop(ras_pop), .pc_vec(pc_vec),
        .slot_valid(slot_valid), .misalign(misalign), .ras_empty(ras_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pcv;
        logic [1:0]  v;
        logic        m;
        logic        e;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ras_q[$];
    logic [31:0] m_pc;
    int          m_state;
    logic        m_mis;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endfunction

    function automatic exp_t model_snapshot();
        exp_t        e;
        logic [31:0] p1;
        p1    = m_pc + 32'd4;
        e.pcv = {p1, m_pc};
        e.v   = (m_state == S_RUN) ? 2'b11 : 2'b00;
        e.m   = m_mis;
        e.e   = RAS_ON ? (ras_q.size() == 0) : 1'b1;
        return e;
    endfunction

    // Reference behaviour for one clock edge, using the inputs presented on it.
    function automatic void model_step();
        logic [31:0] tgt, popped;
        bit          pop_ok, push_ok;
        int          acc;
        popped  = '0;
        pop_ok  = RAS_ON && ras_pop && !redir_valid && (m_state != S_BOOT) && (ras_q.size() > 0);
        push_ok = RAS_ON && ras_push && !redir_valid;
        if (pop_ok) popped = ras_q.pop_back();
        if (push_ok) begin
            ras_q.push_back(ras_push_addr);
            if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
        end
        acc = (int'(accept_cnt) > FW) ? FW : int'(accept_cnt);
        if (m_state == S_BOOT) begin
            m_state = S_RUN;
        end else if (redir_valid) begin
            tgt     = (redir_type < 2) ? redir_pc + redir_off : (redir_base & ~32'd1);
            m_pc    = tgt & ~32'd3;
            m_mis   = tgt[1];
            m_state = S_BUBBLE;
        end else if (pop_ok) begin
            m_pc    = popped;
            m_state = S_BUBBLE;
        end else if (en) begin
            if (m_state == S_BUBBLE) m_state = S_RUN;
            else if (!hold) m_pc = m_pc + 32'(4 * acc);
        end
        sb_q.push_back(model_snapshot());
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("pc_vec",     pc_vec,     e.pcv);
                chk("slot_valid", 64'(slot_valid), 64'(e.v));
                chk("misalign",   64'(misalign),   64'(e.m));
                chk("ras_empty",  64'(ras_empty),  64'(e.e));
            end
        end
    end

    task automatic idle();
        en = 1'b1; hold = 1'b0; accept_cnt = 2'd0; redir_valid = 1'b0; redir_type = 2'b00;
        redir_pc = '0; redir_off = '0; redir_base = '0;
        ras_push = 1'b0; ras_pop = 1'b0; ras_push_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic jump(logic [31:0] base);
        idle(); redir_valid = 1'b1; redir_type = 2'b10; redir_base = base; tick();
        idle(); tick();
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1; idle();
        #1;
        m_pc = RESET_PC; m_state = S_BOOT; m_mis = 1'b0; ras_q.delete();
        chk("rst_pc",    pc_vec, {RESET_PC + 32'd4, RESET_PC});
        chk("rst_valid", 64'(slot_valid), 64'd0);
        chk("rst_mis",   64'(misalign),   64'd0);
        chk("rst_empty", 64'(ras_empty),  64'd1);
        @(posedge clk); @(negedge clk); #1;
        rst = 1'b0; #1;
        chk("boot_valid", 64'(slot_valid), 64'd0);
        chk("boot_pc",    pc_vec, {RESET_PC + 32'd4, RESET_PC});
    endtask

    initial begin
        idle();
        do_reset();

        // Boot then steady accept of two slots.
        accept_cnt = 2'd2; tick(); tick(); tick();

        // Partial accept followed by a held group.
        jump(32'h0001_0010);
        accept_cnt = 2'd1; tick();
        hold = 1'b1; tick(); tick();
        idle(); accept_cnt = 2'd3; tick();

        // Backward branch.
        idle(); redir_valid = 1'b1; redir_type = 2'b00;
        redir_pc = 32'h0001_0020; redir_off = 32'hFFFF_FFF0; tick();
        idle(); accept_cnt = 2'd2; tick(); tick();

        // jalr to an odd target while a pop is requested.
        idle(); ras_push = 1'b1; ras_push_addr = 32'h0000_0300; tick();
        idle(); redir_valid = 1'b1; redir_type = 2'b10; redir_base = 32'h0002_0003;
        ras_pop = 1'b1; tick();
        idle(); redir_valid = 1'b1; redir_type = 2'b11; redir_base = 32'h0003_0005; tick();
        idle(); tick(); tick();

        // Stack overflow and drain.
        for (int i = 0; i < 5; i++) begin
            idle(); ras_push = 1'b1; ras_push_addr = 32'h0000_00A0 + 32'(16 * i); tick();
        end
        for (int i = 0; i < 5; i++) begin
            idle(); ras_pop = 1'b1; tick();
        end
        idle(); ras_push = 1'b1; ras_pop = 1'b1; ras_push_addr = 32'h0000_0700; tick();
        idle(); ras_push = 1'b1; ras_push_addr = 32'h0000_0800; tick();
        idle(); ras_push = 1'b1; ras_pop = 1'b1; ras_push_addr = 32'h0000_0900; tick();
        idle(); tick();

        // Address wrap.
        jump(32'hFFFF_FFFC);
        accept_cnt = 2'd2; tick(); tick();

        // Reset while a redirect bubble is pending.
        idle(); redir_valid = 1'b1; redir_type = 2'b01;
        redir_pc = 32'h0000_4000; redir_off = 32'h0000_0102; tick();
        do_reset();
        idle(); tick(); tick();

        for (int n = 0; n < 400; n++) begin
            idle();
            en          = ($urandom_range(0, 9) != 0);
            hold        = ($urandom_range(0, 4) == 0);
            accept_cnt  = 2'($urandom_range(0, 3));
            redir_valid = ($urandom_range(0, 7) == 0);
            redir_type  = 2'($urandom_range(0, 3));
            redir_pc    = $urandom;
            redir_off   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255)) - 32'd128;
            redir_base  = $urandom;
            ras_push    = ($urandom_range(0, 3) == 0);
            ras_pop     = ($urandom_range(0, 4) == 0);
            ras_push_addr = {$urandom} & ~32'd3;
            tick();
        end
        idle();

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected responses never checked, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
